vga_scan_output: RTL

Final display stage, directly downstream of `pixel_drawer`. The block generates 640x480@60 raster timing from the pixel clock. It supplies the row-within-tile index that `pixel_drawer` uses for ROM addressing, then consumes its per-pixel colour select stream. Each select is mapped through a writable palette to registered RGB, with sync and blanking aligned to the pipeline latency of the upstream drawer.

---
 rtl/vga_scan_output_if.sv | 46 ++++
 rtl/vga_scan_output.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_output_if.sv
// -----------------------------------------------------------------------------
// vga_scan_output_if
//
// Groups the drawer-facing and palette-facing signals of vga_scan_output.
//
// Request/select contract (there is no backpressure anywhere on this bus):
//   pixel_req_o acts as a "valid" for a pixel position. It is high in the
//   cycle the raster counters sit on a visible pixel. The upstream drawer
//   must present the matching select_i exactly PIPE_DELAY cycles later,
//   stable across the edge that ends that cycle. The consumer is always
//   "ready". select_i is ignored whenever the delayed active flag is low.
//   The palette write port is a plain write strobe. pal_we_i qualifies
//   pal_addr_i/pal_data_i on the edge where it is high.
//
// modports:
//   slave  - the scan-output block
//   master - the environment (drawer + palette writer + display sink)
// -----------------------------------------------------------------------------
interface vga_scan_output_if #(
    parameter int SELECT_SIZE = 3,
    parameter int COLOR_WIDTH = 12
);
    logic [SELECT_SIZE-1:0] select_i;
    logic                   pal_we_i;
    logic [SELECT_SIZE-1:0] pal_addr_i;
    logic [COLOR_WIDTH-1:0] pal_data_i;
    logic                   pixel_req_o;
    logic                   frame_start_o;
    logic [4:0]             v_cntr_mod32_o;
    logic                   hsync_o;
    logic                   vsync_o;
    logic                   active_o;
    logic [COLOR_WIDTH-1:0] rgb_o;

    modport slave (
        input  select_i, pal_we_i, pal_addr_i, pal_data_i,
        output pixel_req_o, frame_start_o, v_cntr_mod32_o,
               hsync_o, vsync_o, active_o, rgb_o
    );

    modport master (
        output select_i, pal_we_i, pal_addr_i, pal_data_i,
        input  pixel_req_o, frame_start_o, v_cntr_mod32_o,
               hsync_o, vsync_o, active_o, rgb_o
    );
endinterface

// File: rtl/vga_scan_output.sv
// -----------------------------------------------------------------------------
// vga_scan_output
//
// Final display stage. It generates raster timing from the pixel clock and
// tells the upstream drawer which pixel and tile row are current. It takes
// the drawer's colour select PIPE_DELAY cycles later, maps it through a
// writable palette, and registers RGB together with sync and blanking. The
// sync and blanking signals are delayed so they line up with the colour.
//
// Ports:
//   clk_i   - pixel clock
//   rst_i   - asynchronous, active-high reset
//   bus     - vga_scan_output_if.slave:
//             select_i, pal_we_i, pal_addr_i, pal_data_i        (in)
//             pixel_req_o, frame_start_o, v_cntr_mod32_o        (stage 0)
//             hsync_o, vsync_o, active_o, rgb_o                 (registered,
//                                                    PIPE_DELAY+1 latency)
// -----------------------------------------------------------------------------
module vga_scan_output #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int SELECT_SIZE = 3,
    parameter int COLOR_WIDTH = 12,
    parameter int PIPE_DELAY  = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    vga_scan_output_if.slave  bus
);
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW        = $clog2(H_TOTAL);
    // The row index output needs at least 5 counter bits.
    localparam int VW        = ($clog2(V_TOTAL) < 5) ? 5 : $clog2(V_TOTAL);
    localparam int PAL_DEPTH = 2 ** SELECT_SIZE;

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);

    // Reset contents of the palette. The values are 4:4:4 codes. Indices
    // past 7 come up black.
    function automatic logic [COLOR_WIDTH-1:0] pal_default(input int idx);
        logic [11:0] c;
        case (idx)
            1:       c = 12'hFFF;
            2:       c = 12'hF00;
            3:       c = 12'h0F0;
            4:       c = 12'h00F;
            5:       c = 12'hFF0;
            6:       c = 12'h0FF;
            7:       c = 12'hF0F;
            default: c = 12'h000;
        endcase
        return COLOR_WIDTH'(c);
    endfunction

    // ------------------------------------------------------------------
    // Raster counters. On reset they load their last value, so the first
    // edge after release lands on (0,0).
    // ------------------------------------------------------------------
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;

    always_comb begin
        h_cnt_d = h_cnt_q + HW'(1);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            if (v_cnt_q == V_LAST) begin
                v_cnt_d = '0;
            end else begin
                v_cnt_d = v_cnt_q + VW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            h_cnt_q <= H_LAST;
            v_cnt_q <= V_LAST;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage-0 decode
    // ------------------------------------------------------------------
    logic pixel_req;
    logic hs_raw;
    logic vs_raw;

    assign pixel_req = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
    assign hs_raw    = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
    // vs_raw depends only on v_cnt, so it moves only at line boundaries.
    assign vs_raw    = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));

    assign bus.pixel_req_o    = pixel_req;
    assign bus.frame_start_o  = (h_cnt_q == '0) && (v_cnt_q == '0);
    assign bus.v_cntr_mod32_o = v_cnt_q[4:0];

    // ------------------------------------------------------------------
    // Delay line. The three flags are kept as {hs, vs, active}. Each stage
    // resets to "syncs idle, not active".
    // ------------------------------------------------------------------
    logic [2:0] flags_raw;
    logic [2:0] flags_dly;

    assign flags_raw = {hs_raw, vs_raw, pixel_req};

    generate
        if (PIPE_DELAY == 0) begin : g_nodly
            assign flags_dly = flags_raw;
        end else begin : g_dly
            logic [2:0] stage_q [PIPE_DELAY];

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int i = 0; i < PIPE_DELAY; i++) begin
                        stage_q[i] <= 3'b110;
                    end
                end else begin
                    stage_q[0] <= flags_raw;
                    for (int i = 1; i < PIPE_DELAY; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign flags_dly = stage_q[PIPE_DELAY-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Palette. The lookup below reads pal_q before this edge's write takes
    // effect. So a write and a read of the same index on one edge return
    // the old colour.
    // ------------------------------------------------------------------
    logic [COLOR_WIDTH-1:0] pal_q [PAL_DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < PAL_DEPTH; i++) begin
                pal_q[i] <= pal_default(i);
            end
        end else if (bus.pal_we_i) begin
            pal_q[bus.pal_addr_i] <= bus.pal_data_i;
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    logic                   hsync_q;
    logic                   vsync_q;
    logic                   active_q;
    logic [COLOR_WIDTH-1:0] rgb_q;
    logic [COLOR_WIDTH-1:0] rgb_d;

    // Black outside the visible area, whatever the drawer presents.
    assign rgb_d = flags_dly[0] ? pal_q[bus.select_i] : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            active_q <= 1'b0;
            rgb_q    <= '0;
        end else begin
            hsync_q  <= flags_dly[2];
            vsync_q  <= flags_dly[1];
            active_q <= flags_dly[0];
            rgb_q    <= rgb_d;
        end
    end

    assign bus.hsync_o  = hsync_q;
    assign bus.vsync_o  = vsync_q;
    assign bus.active_o = active_q;
    assign bus.rgb_o    = rgb_q;

endmodule
